instr_fetch_stage: RTL and testbench

//  Fetch stage between instruction memory and the decoder of the single-cycle core.

---
 rtl/instr_fetch_stage_if.sv | 29 ++
 rtl/instr_fetch_stage.sv | 105 ++++++++++
 tb/tb_instr_fetch_stage.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_stage_if.sv
// Fetch-stage bundle: instruction-memory port, redirect input and the
// valid/ready hand-off towards the decoder.
interface instr_fetch_stage_if #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned INSTR_W = 32
);
  logic               fetch_en_in;
  logic [ADDR_W-1:0]  imem_addr_out;
  logic [INSTR_W-1:0] imem_data_in;
  logic               redirect_in;
  logic [ADDR_W-1:0]  redirect_addr_in;
  logic               instr_valid_out;
  logic               instr_ready_in;
  logic [INSTR_W-1:0] instr_out;
  logic [ADDR_W-1:0]  instr_pc_out;
  logic [ADDR_W-1:0]  r15_out;

  // master: the fetch stage itself
  modport master (
    input  fetch_en_in, imem_data_in, redirect_in, redirect_addr_in, instr_ready_in,
    output imem_addr_out, instr_valid_out, instr_out, instr_pc_out, r15_out
  );

  // slave: memory / execute / decoder side
  modport slave (
    output fetch_en_in, imem_data_in, redirect_in, redirect_addr_in, instr_ready_in,
    input  imem_addr_out, instr_valid_out, instr_out, instr_pc_out, r15_out
  );
endinterface

// File: rtl/instr_fetch_stage.sv
// Fetch stage: owns the PC, fetches one word per cycle into a small FIFO and
// hands words to the decoder; execute redirects flush the FIFO and reload the PC.
module instr_fetch_stage #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned INSTR_W  = 32,
  parameter int unsigned PC_STEP  = 4,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned DEPTH    = 2
) (
  input logic                 clk_in,
  input logic                 rst_n_in,
  instr_fetch_stage_if.master bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_FULL} state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } entry_t;

  state_t             state_q, state_d;
  entry_t             mem_q [DEPTH];
  entry_t             mem_d [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic               full, pop, push;
  logic [1:0]         redirect_lsb_unused;

  assign redirect_lsb_unused = bus.redirect_addr_in[1:0];

  always_comb begin
    mem_d      = mem_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    fetch_pc_d = fetch_pc_q;
    state_d    = state_q;

    full = (state_q == ST_FULL) || (count_q == CNT_W'(DEPTH));
    pop  = (count_q != '0) && bus.instr_ready_in;
    push = bus.fetch_en_in && !bus.redirect_in && (!full || pop);

    if (bus.redirect_in) begin
      // A same-cycle pop is consumed by the decoder; everything else is discarded.
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      fetch_pc_d = {bus.redirect_addr_in[ADDR_W-1:2], 2'b00};
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = '{instr: bus.imem_data_in, pc: fetch_pc_q};
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        fetch_pc_d      = fetch_pc_q + ADDR_W'(PC_STEP);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_d = count_q - CNT_W'(1);
      end
    end

    if (!bus.fetch_en_in) begin
      state_d = ST_IDLE;
    end else if (count_d == CNT_W'(DEPTH)) begin
      state_d = ST_FULL;
    end else begin
      state_d = ST_FETCH;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q    <= ST_IDLE;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      fetch_pc_q <= ADDR_W'(RESET_PC);
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  // Storage needs no reset: outputs are gated by count_q.
  always_ff @(posedge clk_in) begin
    mem_q <= mem_d;
  end

  assign bus.imem_addr_out   = fetch_pc_q;
  assign bus.instr_valid_out = (count_q != '0);
  assign bus.instr_out       = bus.instr_valid_out ? mem_q[rd_ptr_q].instr : '0;
  assign bus.instr_pc_out    = bus.instr_valid_out ? mem_q[rd_ptr_q].pc    : '0;
  assign bus.r15_out         = bus.instr_pc_out + ADDR_W'(8);
endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: directed scenarios plus random traffic, checked
// every cycle against a queue-based model of the fetch FIFO and PC.
module tb_instr_fetch_stage;
  localparam int unsigned AW = 8;
  localparam int unsigned IW = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  instr_fetch_stage_if #(.ADDR_W(AW), .INSTR_W(IW)) bus ();

  instr_fetch_stage #(
    .ADDR_W(AW), .INSTR_W(IW), .PC_STEP(4), .RESET_PC(0), .DEPTH(2)
  ) dut (
    .clk_in  (clk),
    .rst_n_in(rst_n),
    .bus     (bus)
  );

  function automatic logic [31:0] imem_word(input logic [7:0] a);
    return 32'hE000_0000 | {24'h0, a};
  endfunction

  assign bus.imem_data_in = imem_word(bus.imem_addr_out);

  typedef struct {
    logic [31:0] instr;
    logic [7:0]  pc;
  } ent_t;

  ent_t        mq[$];
  logic [7:0]  m_pc;
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic compare_model();
    logic        e_v;
    logic [31:0] e_i;
    logic [7:0]  e_pc;
    logic [7:0]  e_r15;
    e_v   = (mq.size() != 0);
    e_i   = e_v ? mq[0].instr : 32'h0;
    e_pc  = e_v ? mq[0].pc : 8'h0;
    e_r15 = e_pc + 8'd8;
    chk("valid", 32'(bus.instr_valid_out), 32'(e_v));
    chk("instr", bus.instr_out, e_i);
    chk("instr_pc", 32'(bus.instr_pc_out), 32'(e_pc));
    chk("r15", 32'(bus.r15_out), 32'(e_r15));
    chk("imem_addr", 32'(bus.imem_addr_out), 32'(m_pc));
  endtask

  task automatic advance_model();
    ent_t e;
    if (!rst_n) begin
      mq.delete();
      m_pc = 8'h00;
      return;
    end
    if (mq.size() != 0 && bus.instr_ready_in) void'(mq.pop_front());
    if (bus.redirect_in) begin
      mq.delete();
      m_pc = bus.redirect_addr_in & 8'hFC;
    end else if (bus.fetch_en_in && mq.size() < 2) begin
      e.instr = imem_word(m_pc);
      e.pc    = m_pc;
      mq.push_back(e);
      m_pc = m_pc + 8'd4;
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare_model();
    advance_model();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic en, input logic rdy,
                       input logic redir, input logic [7:0] addr);
    rst_n                = r;
    bus.fetch_en_in      = en;
    bus.instr_ready_in   = rdy;
    bus.redirect_in      = redir;
    bus.redirect_addr_in = addr;
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    @(posedge clk);
    #1;
    mq.delete();
    m_pc = 8'h00;
    chk("rst_valid", 32'(bus.instr_valid_out), 32'h0);
    chk("rst_r15", 32'(bus.r15_out), 32'h08);

    // 1: free-running fetch
    drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    step();
    chk("s1_pc0", 32'(bus.instr_pc_out), 32'h00);
    chk("s1_instr0", bus.instr_out, 32'hE000_0000);
    chk("s1_r15_0", 32'(bus.r15_out), 32'h08);
    step();
    chk("s1_pc1", 32'(bus.instr_pc_out), 32'h04);
    chk("s1_r15_1", 32'(bus.r15_out), 32'h0C);
    chk("s1_instr1", bus.instr_out, 32'hE000_0004);
    repeat (3) step();

    // 2: decoder stalls, FIFO fills, then drains in order
    drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    step();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    repeat (4) step();
    chk("s2_addr_hold", 32'(bus.imem_addr_out), 32'h08);
    chk("s2_head", 32'(bus.instr_pc_out), 32'h00);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    step();
    chk("s2_next", 32'(bus.instr_pc_out), 32'h04);
    step();
    chk("s2_next2", 32'(bus.instr_pc_out), 32'h08);

    // 3: redirect while head 0x10 is popped
    drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    step();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    repeat (5) step();
    chk("s3_head10", 32'(bus.instr_pc_out), 32'h10);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 8'h43);
    step();
    chk("s3_bubble", 32'(bus.instr_valid_out), 32'h0);
    chk("s3_addr", 32'(bus.imem_addr_out), 32'h40);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    step();
    chk("s3_target", 32'(bus.instr_pc_out), 32'h40);
    chk("s3_target_instr", bus.instr_out, 32'hE000_0040);

    // 4: wrap of the PC
    drive(1'b1, 1'b1, 1'b1, 1'b1, 8'hF8);
    step();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    step(); chk("s4_F8", 32'(bus.instr_pc_out), 32'hF8);
    step(); chk("s4_FC", 32'(bus.instr_pc_out), 32'hFC);
    step(); chk("s4_00", 32'(bus.instr_pc_out), 32'h00);
    chk("s4_r15", 32'(bus.r15_out), 32'h08);
    step(); chk("s4_04", 32'(bus.instr_pc_out), 32'h04);

    // 5: fetch disabled with a full FIFO
    drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    step();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    repeat (3) step();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    step(); chk("s5_drain1", 32'(bus.instr_pc_out), 32'h04);
    step(); chk("s5_empty", 32'(bus.instr_valid_out), 32'h0);
    chk("s5_frozen", 32'(bus.imem_addr_out), 32'h08);
    step(); chk("s5_frozen2", 32'(bus.imem_addr_out), 32'h08);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    step(); chk("s5_resume", 32'(bus.instr_pc_out), 32'h08);

    // 6: reset beats a redirect with a full FIFO
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    repeat (3) step();
    drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h80);
    step();
    chk("s6_valid", 32'(bus.instr_valid_out), 32'h0);
    chk("s6_addr", 32'(bus.imem_addr_out), 32'h00);
    chk("s6_r15", 32'(bus.r15_out), 32'h08);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 99) != 0,
            $urandom_range(0, 9) != 0,
            $urandom_range(0, 9) < 7,
            $urandom_range(0, 99) < 8,
            8'($urandom));
      step();
    end
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
